// File: rtl/conv_pkg.sv
// conv_pkg: shared types for the convolution stream driver.
// State and strobe-kind encodings plus small decode helpers.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    GUARD,
    WAITMW,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    CF,
    FIRST,
    ROWSTART,
    STREAM,
    COEF,
    TERM
  } kind_e;

  typedef struct packed {
    logic sle;
    logic nr;
    logic cle;
  } strobe_t;

  localparam int NUM_COEFF = 3;

  function automatic logic is_sample(kind_e k);
    return (k == FIRST) ||
           (k == ROWSTART) ||
           (k == STREAM);
  endfunction

  function automatic strobe_t kind_strobe(kind_e k);
    strobe_t s;
    s = '0;
    unique case (k)
      CF, FIRST, STREAM: s.sle = 1'b1;
      ROWSTART:          s.nr  = 1'b1;
      COEF:              s.cle = 1'b1;
      TERM: begin
        s.nr  = 1'b1;
        s.sle = 1'b1;
      end
      default:           s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/conv_stream_driver_if.sv
// conv_stream_driver_if: upstream stream plus engine control lines.
// master = driver side, slave = source/engine side.
interface conv_stream_driver_if #(
  parameter int DW = 8
) ();

  logic          src_valid;
  logic [DW-1:0] src_data;
  logic          src_ready;
  logic [DW-1:0] sample_data;
  logic          sample_load_en;
  logic          new_row;
  logic          coeff_load_en;
  logic          modwait;

  modport master (
    input  src_valid,
    input  src_data,
    input  modwait,
    output src_ready,
    output sample_data,
    output sample_load_en,
    output new_row,
    output coeff_load_en
  );

  modport slave (
    output src_valid,
    output src_data,
    output modwait,
    input  src_ready,
    input  sample_data,
    input  sample_load_en,
    input  new_row,
    input  coeff_load_en
  );

endinterface

// File: rtl/conv_mw_timer.sv
// conv_mw_timer: counts engine-busy cycles, flags at TMO.
// Saturates at TMO so the flag holds until cleared.
module conv_mw_timer #(
  parameter int TMO = 64
) (
  input  logic clk,
  input  logic n_rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int CW = $clog2(TMO + 1);

  logic [CW-1:0] cnt_q;

  assign expired = (cnt_q == CW'(TMO));

  // busy-cycle counter, cleared whenever the engine is not stalling us
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/conv_stream_driver.sv
// conv_stream_driver: sequences coefficient and image words
// from a valid/ready stream onto the engine control strobes.
module conv_stream_driver
  import conv_pkg::*;
#(
  parameter int WW  = 8,
  parameter int HW  = 8,
  parameter int DW  = 8,
  parameter int TMO = 64
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic                 coeff_update,
  input  logic [WW-1:0]        img_width,
  input  logic [HW-1:0]        img_height,
  conv_stream_driver_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  state_e        state_q;
  state_e        state_d;
  kind_e         kind_q;
  kind_e         kind_d;
  logic [WW-1:0] w_q;
  logic [HW-1:0] h_q;
  logic [WW-1:0] col_q;
  logic [WW-1:0] col_d;
  logic [HW-1:0] row_q;
  logic [HW-1:0] row_d;
  logic [1:0]    cf_q;
  logic [1:0]    cf_d;
  logic [DW-1:0] data_q;

  logic    take;
  logic    pop;
  logic    bad_dim;
  logic    last_col;
  logic    last_row;
  logic    last_cf;
  logic    tmo;
  logic    tmr_en;
  logic    tmr_clr;
  strobe_t stb;
  logic    src_ready;

  assign take     = (state_q == IDLE) && start;
  assign pop      = src_ready;
  assign bad_dim  = (img_width < WW'(3)) ||
                    (img_height == '0);
  assign last_col = (col_q == w_q - WW'(1));
  assign last_row = (row_q == h_q - HW'(1));
  assign last_cf  = (cf_q == 2'(NUM_COEFF - 1));

  assign tmr_en  = (state_q == WAITMW) && bus.modwait;
  assign tmr_clr = (state_q != WAITMW) || !bus.modwait;

  conv_mw_timer #(
    .TMO (TMO)
  ) u_tmr (
    .clk     (clk),
    .n_rst   (n_rst),
    .en      (tmr_en),
    .clr     (tmr_clr),
    .expired (tmo)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state plus next sequence position
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    col_d   = col_q;
    row_d   = row_q;
    cf_d    = cf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          col_d   = '0;
          row_d   = '0;
          cf_d    = '0;
          kind_d  = coeff_update ? CF : FIRST;
          state_d = bad_dim ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (bus.src_valid) state_d = ISSUE;
      end
      ISSUE:  state_d = GUARD;
      GUARD:  state_d = WAITMW;
      WAITMW: begin
        if (tmo) begin
          state_d = IDLE;
        end else if (!bus.modwait) begin
          unique case (1'b1)
            kind_q == TERM: begin
              state_d = DONE;
            end
            kind_q == COEF: begin
              kind_d  = FIRST;
              col_d   = '0;
              row_d   = '0;
              state_d = FETCH;
            end
            kind_q == CF: begin
              if (last_cf) begin
                kind_d  = COEF;
                state_d = ISSUE;
              end else begin
                cf_d    = cf_q + 2'd1;
                state_d = FETCH;
              end
            end
            is_sample(kind_q): begin
              unique case (1'b1)
                !last_col: begin
                  col_d   = col_q + WW'(1);
                  kind_d  = STREAM;
                  state_d = FETCH;
                end
                last_col && !last_row: begin
                  col_d   = '0;
                  row_d   = row_q + HW'(1);
                  kind_d  = ROWSTART;
                  state_d = FETCH;
                end
                default: begin
                  kind_d  = TERM;
                  state_d = ISSUE;
                end
              endcase
            end
            default: state_d = IDLE;
          endcase
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // frame shadows, sequence counters and presented word
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      w_q    <= '0;
      h_q    <= '0;
      kind_q <= CF;
      col_q  <= '0;
      row_q  <= '0;
      cf_q   <= '0;
      data_q <= '0;
    end else begin
      if (take) begin
        w_q <= img_width;
        h_q <= img_height;
      end
      kind_q <= kind_d;
      col_q  <= col_d;
      row_q  <= row_d;
      cf_q   <= cf_d;
      if (pop) data_q <= bus.src_data;
    end
  end

  // Moore output decode; src_ready alone looks at an input
  always_comb begin
    stb       = '0;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    err       = (state_q == WAITMW) && tmo;
    src_ready = (state_q == FETCH) && bus.src_valid;
    if (state_q == ISSUE) stb = kind_strobe(kind_q);
  end

  assign bus.src_ready      = src_ready;
  assign bus.sample_data    = data_q;
  assign bus.sample_load_en = stb.sle;
  assign bus.new_row        = stb.nr;
  assign bus.coeff_load_en  = stb.cle;

endmodule
